// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter for one AXI channel pair: grant is held per transaction until done_i, with lock and watchdog.
// Grant appears 1 cycle after a request; other requesters simply wait while a grant is held.
module axi_txn_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned LOCK_MAX       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] lock_i,
  input  logic                   done_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   grant_valid_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   timeout_o,
  output logic [IDX_W-1:0]       timeout_idx_o
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LOCK_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [IDX_W-1:0]        timeout_idx_q, timeout_idx_d;

  logic [IDX_W:0]          pick;
  logic [IDX_W-1:0]        ptr_after;
  logic                    lock_ok;
  logic                    wd_fire;

  // Walk candidates from ptr with an explicit wrap so a non-power-of-two N never yields an index >= N.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [IDX_W-1:0]       ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res  = '0;
    cand = ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!res[IDX_W] && req[cand]) begin
        res = {1'b1, cand};
      end
      cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    pick      = rr_pick(req_i, ptr_q);
    ptr_after = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
    lock_ok   = lock_i[grant_idx_q] && req_i[grant_idx_q] && (lock_cnt_q < LOCK_LIM);
    wd_fire   = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    lock_cnt_d    = lock_cnt_q;
    timeout_d     = 1'b0;
    timeout_idx_d = timeout_idx_q;

    unique case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          state_d              = BUSY;
          grant_d              = '0;
          grant_d[pick[IDX_W-1:0]] = 1'b1;
          grant_valid_d        = 1'b1;
          grant_idx_d          = pick[IDX_W-1:0];
          cnt_d                = '0;
        end
      end
      BUSY: begin
        // done_i is checked before the watchdog so a same-cycle completion is a normal release.
        if (done_i && lock_ok) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          cnt_d      = '0;
        end else if (done_i || wd_fire) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          ptr_d         = ptr_after;
          cnt_d         = '0;
          lock_cnt_d    = '0;
          if (!done_i) begin
            timeout_d     = 1'b1;
            timeout_idx_d = grant_idx_q;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      lock_cnt_q    <= '0;
      timeout_q     <= 1'b0;
      timeout_idx_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      timeout_q     <= timeout_d;
      timeout_idx_q <= timeout_idx_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = grant_idx_q;
  assign timeout_o     = timeout_q;
  assign timeout_idx_o = timeout_idx_q;

endmodule
